// File: rtl/sys_controller.sv
`default_nettype none
// ============================================================================
// Module   : sys_controller
// Purpose  : Tile sequencer for a weight-stationary systolic array.
// Revision : 1.0
// ============================================================================
module sys_controller #(
   parameter int SYS_ROWS = 8,
   parameter int A_ROWS   = 16,
   parameter int OF_LAT   = 16,
   parameter int TILE_W   = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic [TILE_W-1:0]         tiles,
   input  logic                      abort,
   input  logic                      w_done,
   input  logic                      if_done,
   output logic                      w_buffer_read,
   output logic                      if_buffer_read,
   output logic                      clr_w,
   output logic                      clr_if,
   output logic                      switch,
   output logic                      of_valid,
   output logic [$clog2(A_ROWS)-1:0] of_row,
   output logic                      busy,
   output logic                      done
);

   localparam int ROW_W = $clog2(A_ROWS);
   localparam logic [ROW_W-1:0] c_row_last = ROW_W'(A_ROWS - 1);

   if (SYS_ROWS < 1 || A_ROWS < 2 || OF_LAT < 1 || OF_LAT > 64) begin : g_param_check
      $error("sys_controller: parameter out of range");
   end

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD_W = 3'd1,
      S_SWITCH = 3'd2,
      S_STREAM = 3'd3,
      S_DRAIN  = 3'd4,
      S_DONE   = 3'd5
   } state_t;

   state_t              r_state;
   state_t              w_next;
   logic [TILE_W-1:0]   r_remaining;
   logic [OF_LAT-1:0]   r_pipe;
   logic [ROW_W-1:0]    r_row;
   logic                w_abort;
   logic                w_accept;
   logic                w_pending;

   assign w_abort  = abort && (r_state != S_IDLE);
   assign w_accept = (r_state == S_IDLE) && start && !abort;
   // Rows still in flight behind the one currently presented on of_valid.
   assign w_pending = |(r_pipe << 1);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next         = r_state;
      w_buffer_read  = 1'b0;
      if_buffer_read = 1'b0;
      switch         = 1'b0;
      clr_w          = 1'b1;
      clr_if         = 1'b1;
      busy           = 1'b1;
      done           = 1'b0;
      case (r_state)
         S_IDLE: begin
            busy = 1'b0;
            if (w_accept) begin
               w_next = (tiles != '0) ? S_LOAD_W : S_DONE;
            end
         end
         S_LOAD_W: begin
            w_buffer_read = 1'b1;
            clr_w         = 1'b0;
            if (w_done) begin
               w_next = S_SWITCH;
            end
         end
         S_SWITCH: begin
            switch = 1'b1;
            w_next = S_STREAM;
         end
         S_STREAM: begin
            if_buffer_read = 1'b1;
            clr_if         = 1'b0;
            if (if_done) begin
               w_next = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (!w_pending) begin
               w_next = (r_remaining != '0) ? S_LOAD_W : S_DONE;
            end
         end
         S_DONE: begin
            done   = 1'b1;
            w_next = S_IDLE;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
      if (w_abort) begin
         w_next = S_IDLE;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_remaining <= '0;
      end else if (w_abort) begin
         r_remaining <= '0;
      end else if (w_accept && (tiles != '0)) begin
         r_remaining <= tiles;
      end else if ((r_state == S_STREAM) && if_done) begin
         r_remaining <= r_remaining - 1'b1;
      end
   end

   // Output-row tracker: read strobes travel OF_LAT stages to become of_valid.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_pipe <= '0;
         r_row  <= '0;
      end else if (w_abort) begin
         r_pipe <= '0;
         r_row  <= '0;
      end else begin
         r_pipe <= (r_pipe << 1) | OF_LAT'(if_buffer_read);
         if (of_valid) begin
            r_row <= (r_row == c_row_last) ? '0 : r_row + 1'b1;
         end
      end
   end

   assign of_valid = r_pipe[OF_LAT-1];
   assign of_row   = r_row;

endmodule
`default_nettype wire

// File: tb/tb_sys_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_sys_controller
// Purpose  : Directed self-checking bench for sys_controller.
// Revision : 1.0
// ============================================================================
module tb_sys_controller;

   localparam int SYS_ROWS = 4;
   localparam int A_ROWS   = 6;
   localparam int OF_LAT   = 7;
   localparam int TILE_W   = 8;
   // One tile: 4 load + 1 switch + 6 stream + 7 drain cycles.
   localparam int TILE_LEN = 18;
   // {done,busy,of_valid,switch,if_rd,w_rd,clr_if,clr_w}
   localparam logic [7:0] IDLE_VEC = 8'b0000_0011;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              start = 1'b0;
   logic [TILE_W-1:0] tiles = '0;
   logic              abort = 1'b0;
   logic              w_done;
   logic              if_done;
   logic              w_buffer_read, if_buffer_read, clr_w, clr_if, switch;
   logic              of_valid, busy, done;
   logic [2:0]        of_row;

   int checks   = 0;
   int failures = 0;

   logic [7:0] tr_vec [0:63];
   logic [2:0] tr_row [0:63];

   always #5 clk = ~clk;

   sys_controller #(
      .SYS_ROWS(SYS_ROWS), .A_ROWS(A_ROWS), .OF_LAT(OF_LAT), .TILE_W(TILE_W)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .tiles(tiles), .abort(abort),
      .w_done(w_done), .if_done(if_done),
      .w_buffer_read(w_buffer_read), .if_buffer_read(if_buffer_read),
      .clr_w(clr_w), .clr_if(clr_if), .switch(switch),
      .of_valid(of_valid), .of_row(of_row), .busy(busy), .done(done)
   );

   // Datapath read counters producing the terminal flags.
   int w_cnt = 0;
   int if_cnt = 0;
   always @(posedge clk) begin
      if (clr_w) w_cnt <= 0; else if (w_buffer_read) w_cnt <= w_cnt + 1;
      if (clr_if) if_cnt <= 0; else if (if_buffer_read) if_cnt <= if_cnt + 1;
   end
   assign w_done  = w_buffer_read && (w_cnt == SYS_ROWS - 1);
   assign if_done = if_buffer_read && (if_cnt == A_ROWS - 1);

   function automatic logic [7:0] cur_vec();
      return {done, busy, of_valid, switch, if_buffer_read, w_buffer_read, clr_if, clr_w};
   endfunction

   function automatic logic [7:0] exp_vec(input int c, input int ntiles, input int cut);
      logic wr, sw, ir, ov, bz, dn;
      int   last;
      wr = 1'b0; sw = 1'b0; ir = 1'b0; ov = 1'b0;
      last = (ntiles == 0) ? 1 : TILE_LEN * ntiles + 1;
      for (int k = 0; k < ntiles; k++) begin
         if (c >= TILE_LEN*k + 1  && c <= TILE_LEN*k + 4)  wr = 1'b1;
         if (c == TILE_LEN*k + 5)                          sw = 1'b1;
         if (c >= TILE_LEN*k + 6  && c <= TILE_LEN*k + 11) ir = 1'b1;
         if (c >= TILE_LEN*k + 13 && c <= TILE_LEN*k + 18) ov = 1'b1;
      end
      bz = (c >= 1) && (c <= last);
      dn = (c == last);
      if (cut > 0 && c > cut) return IDLE_VEC;
      return {dn, bz, ov, sw, ir, wr, ~ir, ~wr};
   endfunction

   task automatic launch(input logic [TILE_W-1:0] t);
      @(negedge clk);
      start = 1'b1;
      tiles = t;
      @(posedge clk);
      #1;
      start = 1'b0;
      tiles = '0;
   endtask

   // Records cycles 1..n; abort/start pulses land in the named cycle.
   task automatic capture(input int n, input int abort_at, input int start_at);
      for (int c = 1; c <= n; c++) begin
         if (c > 1) begin
            @(posedge clk);
            #1;
         end
         abort = (c == abort_at);
         start = (c == start_at);
         tiles = (c == start_at) ? 8'd3 : 8'd0;
         tr_vec[c] = cur_vec();
         tr_row[c] = of_row;
      end
      abort = 1'b0;
      start = 1'b0;
      tiles = '0;
   endtask

   task automatic test_reset();
      #1 rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (cur_vec() !== IDLE_VEC) begin
         failures++;
         $display("FAIL reset_outputs: got %b expected %b", cur_vec(), IDLE_VEC);
      end
      checks++;
      if (of_row !== 3'd0) begin
         failures++;
         $display("FAIL reset_of_row: got %0d expected 0", of_row);
      end
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_single_tile();
      launch(8'd1);
      capture(24, 0, 0);
      for (int c = 1; c <= 24; c++) begin
         checks++;
         if (tr_vec[c] !== exp_vec(c, 1, 0)) begin
            failures++;
            $display("FAIL single_tile cycle %0d: got %b expected %b", c, tr_vec[c], exp_vec(c, 1, 0));
         end
         if (exp_vec(c, 1, 0)[5]) begin
            checks++;
            if (tr_row[c] !== 3'((c - 13) % TILE_LEN)) begin
               failures++;
               $display("FAIL single_tile_row cycle %0d: got %0d expected %0d", c, tr_row[c], (c - 13) % TILE_LEN);
            end
         end
      end
   endtask

   task automatic test_two_tiles();
      launch(8'd2);
      capture(42, 0, 0);
      for (int c = 1; c <= 42; c++) begin
         checks++;
         if (tr_vec[c] !== exp_vec(c, 2, 0)) begin
            failures++;
            $display("FAIL two_tiles cycle %0d: got %b expected %b", c, tr_vec[c], exp_vec(c, 2, 0));
         end
         if (exp_vec(c, 2, 0)[5]) begin
            checks++;
            if (tr_row[c] !== 3'((c - 13) % TILE_LEN)) begin
               failures++;
               $display("FAIL two_tiles_row cycle %0d: got %0d expected %0d", c, tr_row[c], (c - 13) % TILE_LEN);
            end
         end
      end
   endtask

   task automatic test_zero_tiles();
      launch(8'd0);
      capture(4, 0, 0);
      for (int c = 1; c <= 4; c++) begin
         checks++;
         if (tr_vec[c] !== exp_vec(c, 0, 0)) begin
            failures++;
            $display("FAIL zero_tiles cycle %0d: got %b expected %b", c, tr_vec[c], exp_vec(c, 0, 0));
         end
      end
   endtask

   task automatic test_abort();
      launch(8'd1);
      capture(24, 8, 0);
      for (int c = 1; c <= 24; c++) begin
         checks++;
         if (tr_vec[c] !== exp_vec(c, 1, 8)) begin
            failures++;
            $display("FAIL abort cycle %0d: got %b expected %b", c, tr_vec[c], exp_vec(c, 1, 8));
         end
      end
   endtask

   task automatic test_start_while_busy();
      launch(8'd1);
      capture(30, 0, 8);
      for (int c = 1; c <= 30; c++) begin
         checks++;
         if (tr_vec[c] !== exp_vec(c, 1, 0)) begin
            failures++;
            $display("FAIL start_while_busy cycle %0d: got %b expected %b", c, tr_vec[c], exp_vec(c, 1, 0));
         end
      end
   endtask

   task automatic test_abort_idle();
      @(negedge clk);
      start = 1'b1;
      tiles = 8'd1;
      abort = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      tiles = '0;
      abort = 1'b0;
      for (int c = 1; c <= 3; c++) begin
         checks++;
         if (cur_vec() !== IDLE_VEC) begin
            failures++;
            $display("FAIL abort_beats_start cycle %0d: got %b expected %b", c, cur_vec(), IDLE_VEC);
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_async_reset();
      launch(8'd1);
      capture(7, 0, 0);
      checks++;
      if (tr_vec[7] !== exp_vec(7, 1, 0)) begin
         failures++;
         $display("FAIL pre_reset cycle 7: got %b expected %b", tr_vec[7], exp_vec(7, 1, 0));
      end
      #2 rst = 1'b0;
      #1;
      checks++;
      if (cur_vec() !== IDLE_VEC) begin
         failures++;
         $display("FAIL async_reset_immediate: got %b expected %b", cur_vec(), IDLE_VEC);
      end
      checks++;
      if (of_row !== 3'd0) begin
         failures++;
         $display("FAIL async_reset_of_row: got %0d expected 0", of_row);
      end
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      for (int c = 1; c <= 24; c++) begin
         @(posedge clk);
         #1;
         checks++;
         if (cur_vec() !== IDLE_VEC) begin
            failures++;
            $display("FAIL post_reset_idle cycle %0d: got %b expected %b", c, cur_vec(), IDLE_VEC);
         end
      end
      launch(8'd0);
      capture(2, 0, 0);
      for (int c = 1; c <= 2; c++) begin
         checks++;
         if (tr_vec[c] !== exp_vec(c, 0, 0)) begin
            failures++;
            $display("FAIL post_reset_job cycle %0d: got %b expected %b", c, tr_vec[c], exp_vec(c, 0, 0));
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_tile();
      test_two_tiles();
      test_zero_tiles();
      test_abort();
      test_start_while_busy();
      test_abort_idle();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
